// File: rtl/sc_lifelevel_pkg.sv
// sc_lifelevel_pkg: shared state encoding, default parameters and command priority indices
// Contents:
//    state_t        - IDLE/PLAY/GUARD/OVER 2-bit encoding
//    DEF_*          - default parameter values for sc_lifelevel_tracker
//    CMD_*          - command vector bit positions, lowest index = highest priority
package sc_lifelevel_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      GUARD = 2'd2,
      OVER  = 2'd3
   } state_t;
   localparam int DEF_LIVES_INIT   = 3;
   localparam int DEF_LIVES_WIDTH  = 2;
   localparam int DEF_LEVEL_MAX    = 4;
   localparam int DEF_LEVEL_WIDTH  = 3;
   localparam int DEF_GUARD_CYCLES = 25000000;
   localparam int DEF_GUARD_WIDTH  = 25;
   localparam int CMD_START = 0;
   localparam int CMD_CLEAR = 1;
   localparam int CMD_LOSE  = 2;
   localparam int CMD_NEXT  = 3;
   localparam int CMD_COUNT = 4;
endpackage

// File: rtl/sc_lifelevel_if.sv
// sc_lifelevel_if: command/status bundle between the game FSM (master) and the tracker (slave)
// Signals:
//    *_InLow commands   - active-low command pulses and raw collision, driven by master
//    *_OutLow statuses  - active-low comparators polled by the FSM, driven by slave
//    Lives/Level buses  - counters for display; Guard_Out high during the guard window
interface sc_lifelevel_if #(
   parameter int LIVES_WIDTH = 2,
   parameter int LEVEL_WIDTH = 3
);
   logic                   SC_LIFELEVEL_StartGame_InLow;
   logic                   SC_LIFELEVEL_LifesSignal_InLow;
   logic                   SC_LIFELEVEL_NextLevel_InLow;
   logic                   SC_LIFELEVEL_ClearLost_InLow;
   logic                   SC_LIFELEVEL_Collision_InLow;
   logic                   SC_LIFELEVEL_MatrixComparator_OutLow;
   logic                   SC_LIFELEVEL_LifesCounterComparator_OutLow;
   logic                   SC_LIFELEVEL_LevelCounterComparator_OutLow;
   logic [LIVES_WIDTH-1:0] SC_LIFELEVEL_Lives_OutBUS;
   logic [LEVEL_WIDTH-1:0] SC_LIFELEVEL_Level_OutBUS;
   logic                   SC_LIFELEVEL_Guard_Out;
   modport master (
      output SC_LIFELEVEL_StartGame_InLow, SC_LIFELEVEL_LifesSignal_InLow,
             SC_LIFELEVEL_NextLevel_InLow, SC_LIFELEVEL_ClearLost_InLow,
             SC_LIFELEVEL_Collision_InLow,
      input  SC_LIFELEVEL_MatrixComparator_OutLow, SC_LIFELEVEL_LifesCounterComparator_OutLow,
             SC_LIFELEVEL_LevelCounterComparator_OutLow, SC_LIFELEVEL_Lives_OutBUS,
             SC_LIFELEVEL_Level_OutBUS, SC_LIFELEVEL_Guard_Out
   );
   modport slave (
      input  SC_LIFELEVEL_StartGame_InLow, SC_LIFELEVEL_LifesSignal_InLow,
             SC_LIFELEVEL_NextLevel_InLow, SC_LIFELEVEL_ClearLost_InLow,
             SC_LIFELEVEL_Collision_InLow,
      output SC_LIFELEVEL_MatrixComparator_OutLow, SC_LIFELEVEL_LifesCounterComparator_OutLow,
             SC_LIFELEVEL_LevelCounterComparator_OutLow, SC_LIFELEVEL_Lives_OutBUS,
             SC_LIFELEVEL_Level_OutBUS, SC_LIFELEVEL_Guard_Out
   );
endinterface

// File: rtl/sc_lifelevel_edgedet.sv
// sc_lifelevel_edgedet: falling-edge detector for one active-low command input
// Ports:
//    SC_EDGEDET_CLOCK_50     - clock
//    SC_EDGEDET_RESET_InLow  - async active-low reset, history resets to 1
//    SC_EDGEDET_Signal_InLow - active-low command level
//    SC_EDGEDET_Fire_Out     - high in the cycle the input is low after being high
module sc_lifelevel_edgedet (
   input  logic SC_EDGEDET_CLOCK_50,
   input  logic SC_EDGEDET_RESET_InLow,
   input  logic SC_EDGEDET_Signal_InLow,
   output logic SC_EDGEDET_Fire_Out
);
   logic prevLevel;
   always_ff @(posedge SC_EDGEDET_CLOCK_50 or negedge SC_EDGEDET_RESET_InLow)
      if (!SC_EDGEDET_RESET_InLow) prevLevel <= 1'b1;
      else prevLevel <= SC_EDGEDET_Signal_InLow;
   // Combinational fire so the command acts on the same edge that first samples it low
   assign SC_EDGEDET_Fire_Out = prevLevel & ~SC_EDGEDET_Signal_InLow;
endmodule

// File: rtl/sc_lifelevel_tracker.sv
// sc_lifelevel_tracker: lives/level counters, guard window and status comparators for the game FSM
// Ports:
//    SC_LIFELEVEL_CLOCK_50    - clock
//    SC_LIFELEVEL_RESET_InLow - async active-low reset
//    lifeBus                  - sc_lifelevel_if.slave command/status bundle
// Build option: SC_LIFELEVEL_BONUSLIFE_EN adds one life per level actually gained.
module sc_lifelevel_tracker
   import sc_lifelevel_pkg::*;
#(
   parameter int LIVES_INIT   = DEF_LIVES_INIT,
   parameter int LIVES_WIDTH  = DEF_LIVES_WIDTH,
   parameter int LEVEL_MAX    = DEF_LEVEL_MAX,
   parameter int LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
   parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
   parameter int GUARD_WIDTH  = DEF_GUARD_WIDTH
) (
   input logic         SC_LIFELEVEL_CLOCK_50,
   input logic         SC_LIFELEVEL_RESET_InLow,
   sc_lifelevel_if.slave lifeBus
);
   localparam int LIVES_MAX = (1 << LIVES_WIDTH) - 1;
   localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'((LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT);
   localparam logic [LIVES_WIDTH-1:0] LIVES_TOP = LIVES_WIDTH'(LIVES_MAX);
   localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP = LEVEL_WIDTH'(LEVEL_MAX);
   localparam logic [GUARD_WIDTH-1:0] GUARD_LOAD = GUARD_WIDTH'(GUARD_CYCLES - 1);
   state_t                 stateReg, stateNxt;
   logic [LIVES_WIDTH-1:0] livesReg, livesNxt, livesDec, livesAdj;
   logic [LEVEL_WIDTH-1:0] levelReg, levelNxt;
   logic [GUARD_WIDTH-1:0] timerReg, timerNxt;
   logic [CMD_COUNT-1:0]   cmdRaw, cmdFire;
   logic                   levelUp, gameActive;
   assign cmdRaw[CMD_START] = lifeBus.SC_LIFELEVEL_StartGame_InLow;
   assign cmdRaw[CMD_CLEAR] = lifeBus.SC_LIFELEVEL_ClearLost_InLow;
   assign cmdRaw[CMD_LOSE]  = lifeBus.SC_LIFELEVEL_LifesSignal_InLow;
   assign cmdRaw[CMD_NEXT]  = lifeBus.SC_LIFELEVEL_NextLevel_InLow;
   for (genvar i = 0; i < CMD_COUNT; i++) begin : gEdge
      sc_lifelevel_edgedet uEdge (
         .SC_EDGEDET_CLOCK_50    (SC_LIFELEVEL_CLOCK_50),
         .SC_EDGEDET_RESET_InLow (SC_LIFELEVEL_RESET_InLow),
         .SC_EDGEDET_Signal_InLow(cmdRaw[i]),
         .SC_EDGEDET_Fire_Out    (cmdFire[i])
      );
   end
   always_ff @(posedge SC_LIFELEVEL_CLOCK_50 or negedge SC_LIFELEVEL_RESET_InLow)
      if (!SC_LIFELEVEL_RESET_InLow) begin
         stateReg <= IDLE;
         livesReg <= '0;
         levelReg <= '0;
         timerReg <= '0;
      end else begin
         stateReg <= stateNxt;
         livesReg <= livesNxt;
         levelReg <= levelNxt;
         timerReg <= timerNxt;
      end
   assign gameActive = (stateReg == PLAY) || (stateReg == GUARD);
   assign livesDec = (livesReg == '0) ? '0 : livesReg - 1'b1;
   assign levelUp = cmdFire[CMD_NEXT] && (levelReg != LEVEL_TOP);
   always_comb begin
      stateNxt = stateReg;
      livesNxt = livesReg;
      levelNxt = levelReg;
      timerNxt = timerReg;
      livesAdj = livesReg;
      if (cmdFire[CMD_START]) begin
         stateNxt = PLAY;
         livesNxt = LIVES_LOAD;
         levelNxt = '0;
         timerNxt = '0;
      end else if (gameActive) begin
         if (cmdFire[CMD_CLEAR]) stateNxt = OVER;
         else begin
            // Lose-life only counts outside the guard window
            livesAdj = (stateReg == PLAY && cmdFire[CMD_LOSE]) ? livesDec : livesReg;
            levelNxt = levelUp ? levelReg + 1'b1 : levelReg;
`ifdef SC_LIFELEVEL_BONUSLIFE_EN
            livesNxt = (levelUp && livesAdj != LIVES_TOP) ? livesAdj + 1'b1 : livesAdj;
`else
            livesNxt = livesAdj;
`endif
            if (stateReg == PLAY) begin
               // Respawn guard only when a life remains after the loss
               if (cmdFire[CMD_LOSE] && livesDec != '0) begin
                  stateNxt = GUARD;
                  timerNxt = GUARD_LOAD;
               end
            end else begin
               stateNxt = (timerReg == '0) ? PLAY : GUARD;
               timerNxt = (timerReg == '0) ? '0 : timerReg - 1'b1;
            end
         end
      end
   end
   assign lifeBus.SC_LIFELEVEL_Guard_Out = (stateReg == GUARD);
   assign lifeBus.SC_LIFELEVEL_LifesCounterComparator_OutLow = ~(gameActive && livesReg == '0);
   assign lifeBus.SC_LIFELEVEL_LevelCounterComparator_OutLow = ~(gameActive && levelReg == LEVEL_TOP);
   assign lifeBus.SC_LIFELEVEL_MatrixComparator_OutLow = gameActive ? (lifeBus.SC_LIFELEVEL_Collision_InLow | (stateReg == GUARD)) : 1'b1;
   assign lifeBus.SC_LIFELEVEL_Lives_OutBUS = livesReg;
   assign lifeBus.SC_LIFELEVEL_Level_OutBUS = levelReg;
endmodule
